sync_fifo: RTL and testbench

//   Single-clock synchronous FIFO: a circular buffer of DEPTH entries, each WIDTH bits wide.

---
 rtl/sync_fifo.sv | 66 ++++++
 tb/tb_sync_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular-buffer FIFO with full/empty flow control.
// Defining FIFO_ERR_FLAGS_EN adds registered overflow/underflow pulse outputs.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow,
    output logic             underflow
`endif
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR-1:0]  wr_ptr, rd_ptr;
    logic [ADDR:0]    count;
    logic             wr_ok, rd_ok;

    assign full  = count == (ADDR+1)'(DEPTH);
    assign empty = count == '0;
    // A read from a full FIFO frees the slot the same-cycle write fills.
    assign wr_ok = wr_en && (!full || rd_en);
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk)
        if (wr_ok)
            mem[wr_ptr] <= data_in;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + ADDR'(1);
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + ADDR'(1);
                data_out <= mem[rd_ptr];
            end
            if (wr_ok && !rd_ok)
                count <= count + (ADDR+1)'(1);
            else if (rd_ok && !wr_ok)
                count <= count - (ADDR+1)'(1);
        end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= wr_en && !wr_ok;
            underflow <= rd_en && !rd_ok;
        end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed scenarios for sync_fifo with hand-computed expectations.
// Error-flag checks are included when FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full, empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DEPTH(16), .WIDTH(8), .ADDR(4)) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .data_in(data_in),
        .data_out(data_out),
        .full(full),
        .empty(empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow(overflow),
        .underflow(underflow)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        checks += 3;
        if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", full); end
        if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", data_out); end
        rst = 1'b1;
        tick();
        checks += 2;
        if (empty !== 1'b1) begin errors++; $display("FAIL idle_empty got=%b want=1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL idle_full got=%b want=0", full); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            data_in = 8'(i);
            tick();
            checks += 2;
            if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got=%b want=0", i, empty); end
            if (full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d] got=%b want=%b", i, full, i == 15); end
        end
        data_in = 8'hAA;
        tick();
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL overfill_full got=%b want=1", full); end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_pulse got=%b want=1", overflow); end
        tick();
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got=%b want=0", overflow); end
`endif
    endtask

    task automatic test_full_rw();
        wr_en = 1'b1;
        rd_en = 1'b1;
        data_in = 8'h55;
        tick();
        checks += 2;
        if (data_out !== 8'h00) begin errors++; $display("FAIL full_rw0_data got=%h want=00", data_out); end
        if (full !== 1'b1) begin errors++; $display("FAIL full_rw0_full got=%b want=1", full); end
        data_in = 8'h66;
        tick();
        checks += 2;
        if (data_out !== 8'h01) begin errors++; $display("FAIL full_rw1_data got=%h want=01", data_out); end
        if (full !== 1'b1) begin errors++; $display("FAIL full_rw1_full got=%b want=1", full); end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_drain();
        logic [7:0] exp [16];
        for (int i = 0; i < 14; i++) exp[i] = 8'(i + 2);
        exp[14] = 8'h55;
        exp[15] = 8'h66;
        rd_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            checks += 3;
            if (data_out !== exp[k]) begin errors++; $display("FAIL drain_data[%0d] got=%h want=%h", k, data_out, exp[k]); end
            if (empty !== (k == 15)) begin errors++; $display("FAIL drain_empty[%0d] got=%b want=%b", k, empty, k == 15); end
            if (full !== 1'b0) begin errors++; $display("FAIL drain_full[%0d] got=%b want=0", k, full); end
        end
        tick();
        rd_en = 1'b0;
        checks += 2;
        if (data_out !== 8'h66) begin errors++; $display("FAIL underread_hold got=%h want=66", data_out); end
        if (empty !== 1'b1) begin errors++; $display("FAIL underread_empty got=%b want=1", empty); end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_pulse got=%b want=1", underflow); end
        tick();
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear got=%b want=0", underflow); end
`endif
    endtask

    task automatic test_empty_rw();
        wr_en = 1'b1;
        rd_en = 1'b1;
        data_in = 8'h3C;
        tick();
        wr_en = 1'b0;
        checks += 2;
        if (empty !== 1'b0) begin errors++; $display("FAIL empty_rw_empty got=%b want=0", empty); end
        if (data_out !== 8'h66) begin errors++; $display("FAIL empty_rw_hold got=%h want=66", data_out); end
`ifdef FIFO_ERR_FLAGS_EN
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL empty_rw_underflow got=%b want=1", underflow); end
`endif
        tick();
        rd_en = 1'b0;
        checks += 2;
        if (data_out !== 8'h3C) begin errors++; $display("FAIL empty_rw_read got=%h want=3c", data_out); end
        if (empty !== 1'b1) begin errors++; $display("FAIL empty_rw_drained got=%b want=1", empty); end
    endtask

    task automatic test_mid_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'(8'h11 + i);
            tick();
        end
        wr_en = 1'b0;
        checks++;
        if (empty !== 1'b0) begin errors++; $display("FAIL prereset_empty got=%b want=0", empty); end
        #2 rst = 1'b0;
        #1;
        checks += 3;
        if (empty !== 1'b1) begin errors++; $display("FAIL async_reset_empty got=%b want=1", empty); end
        if (data_out !== 8'h00) begin errors++; $display("FAIL async_reset_data got=%h want=00", data_out); end
        if (full !== 1'b0) begin errors++; $display("FAIL async_reset_full got=%b want=0", full); end
        #1 rst = 1'b1;
        wr_en = 1'b1;
        data_in = 8'hA1;
        tick();
        data_in = 8'hA2;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        checks++;
        if (data_out !== 8'hA1) begin errors++; $display("FAIL post_reset_read0 got=%h want=a1", data_out); end
        tick();
        rd_en = 1'b0;
        checks += 2;
        if (data_out !== 8'hA2) begin errors++; $display("FAIL post_reset_read1 got=%h want=a2", data_out); end
        if (empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty got=%b want=1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_rw();
        test_drain();
        test_empty_rw();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
